dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 65 ++++++
 rtl/dmem_lsu.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes,
// FSM states and the latency counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Holds LATENCY-1, which is at most 7.
  localparam int CNT_W = 3;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store merge into the addressed word,
// load extraction with sign/zero extension, and alignment/size checking.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [$clog2(DATA_W/8)-1:0] i_off,
  input  size_e                       i_size,
  input  logic                        i_unsigned,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic [DATA_W-1:0]           i_word,
  output logic [DATA_W-1:0]           o_merged,
  output logic [DATA_W-1:0]           o_load,
  output logic                        o_error
);

  localparam int OFF_W = $clog2(DATA_W/8);

  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_lane_mask;
  logic [DATA_W-1:0] w_shifted;
  logic [OFF_W-1:0]  w_align;
  logic [OFF_W+2:0]  w_shamt;
  logic              w_sign;
  logic              w_illegal;

  assign w_shamt   = {i_off, 3'b000};
  assign w_shifted = i_word >> w_shamt;

  // w_mask covers the access width at bit 0; w_align holds the offset bits
  // that must be zero for a naturally aligned access of that width.
  always_comb begin
    w_mask    = '1;
    w_align   = OFF_W'(7);
    w_sign    = w_shifted[DATA_W-1];
    w_illegal = 1'b0;
    case (i_size)
      SZ_B: begin
        w_mask  = DATA_W'(8'hFF);
        w_align = '0;
        w_sign  = w_shifted[7];
      end
      SZ_H: begin
        w_mask  = DATA_W'(16'hFFFF);
        w_align = OFF_W'(1);
        w_sign  = w_shifted[15];
      end
      SZ_W: begin
        w_mask  = DATA_W'(32'hFFFF_FFFF);
        w_align = OFF_W'(3);
        w_sign  = w_shifted[31];
      end
      default: begin
        w_illegal = (DATA_W == 32);
      end
    endcase
  end

  assign w_lane_mask = w_mask << w_shamt;
  assign o_merged    = (i_word & ~w_lane_mask) | ((i_wdata & w_mask) << w_shamt);
  assign o_load      = (w_shifted & w_mask) | ((!i_unsigned && w_sign) ? ~w_mask : '0);
  assign o_error     = w_illegal || ((i_off & w_align) != '0);

endmodule

// File: rtl/dmem_lsu.sv
// Single-port data memory with a fixed-latency load/store handshake; one
// request in flight, response returned LATENCY edges after accept.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_hold_err;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_error;

  logic              w_accept;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_rsp_data;
  logic              w_error;
  logic              w_unused_addr_hi;

  // Address bits above the array span are dropped so accesses wrap.
  assign w_idx            = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_off            = req_addr[OFF_W-1:0];
  assign w_unused_addr_hi = ^req_addr[DATA_W-1:OFF_W+IDX_W];
  assign w_word           = r_mem[w_idx];

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

  dmem_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .i_off      (w_off),
    .i_size     (size_e'(req_size)),
    .i_unsigned (req_unsigned),
    .i_wdata    (req_wdata),
    .i_word     (w_word),
    .o_merged   (w_merged),
    .o_load     (w_load),
    .o_error    (w_error)
  );

  assign w_rsp_data = (req_write || w_error) ? '0 : w_load;

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_error) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hold_data <= '0;
      r_hold_err  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_error <= 1'b0;
          if (w_accept) begin
            r_hold_data <= w_rsp_data;
            r_hold_err  <= w_error;
            if (LATENCY == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_data;
              r_rsp_error <= w_error;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= RESP;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_hold_data;
            r_rsp_error <= r_hold_err;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_error <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule
